// File: rtl/sprite_anim_pkg.sv
// Shared encodings and walk-sequence helpers for the sprite animation sequencer.
// Build option: define SPRITE_PINGPONG_EN for the 1,2,3,2 leg-swing sequence.
package sprite_anim_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WALK_L = 2'd1,
    WALK_R = 2'd2
  } anim_state_e;

  localparam logic [2:0] FRAME_IDLE   = 3'd0;
  localparam logic [2:0] FRAME_L_BASE = 3'd0;
  localparam logic [2:0] FRAME_R_BASE = 3'd3;

  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;

  localparam int TICK_DIV_DEFAULT = 25555556;

  // Walk frame offset (1..3) for a phase.
  function automatic logic [2:0] seq_frame(input logic [1:0] p);
`ifdef SPRITE_PINGPONG_EN
    case (p)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      2'd2:    return 3'd3;
      default: return 3'd2;
    endcase
`else
    // Phase 3 is unreachable here; treat it as phase 0.
    case (p)
      2'd1:    return 3'd2;
      2'd2:    return 3'd3;
      default: return 3'd1;
    endcase
`endif
  endfunction

  function automatic logic [1:0] next_phase(input logic [1:0] p);
`ifdef SPRITE_PINGPONG_EN
    return p + 2'd1;
`else
    return (p >= 2'd2) ? 2'd0 : p + 2'd1;
`endif
  endfunction

  function automatic logic [2:0] frame_of(input anim_state_e s, input logic [1:0] p);
    case (s)
      WALK_L:  return FRAME_L_BASE + seq_frame(p);
      WALK_R:  return FRAME_R_BASE + seq_frame(p);
      default: return FRAME_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/sprite_anim_ctrl_tick_div.sv
// Free-running animation tick divider: one-cycle tick every TICK_DIV clocks.
module anim_tick_div #(
  parameter int TICK_DIV = 8,
  parameter int CNT_W    = 27
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt <= '0;
    else      cnt <= tick ? '0 : cnt + CNT_W'(1);
  end

endmodule

// File: rtl/sprite_anim_ctrl.sv
// Player sprite walk-cycle sequencer; frame changes commit only on frame_start.
// Build option: SPRITE_PINGPONG_EN selects the 4-phase ping-pong walk sequence.
module sprite_anim_ctrl
  import sprite_anim_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEFAULT,
  parameter int CNT_W    = 27
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] btn,
  input  logic       frame_start,
  output logic [2:0] frame_sel,
  output logic [1:0] anim_state,
  output logic       frame_update
);

  logic        tick;
  logic [1:0]  sync1, sync2;   // {right, left}
  logic        tick_pending;
  logic [1:0]  phase;
  anim_state_e state, req;
  logic [1:0]  phase_adv;

  anim_tick_div #(.TICK_DIV(TICK_DIV), .CNT_W(CNT_W)) u_tick_div (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {btn[BTN_RIGHT], btn[BTN_LEFT]};
      sync2 <= sync1;
    end
  end

  always_comb begin
    req = IDLE;
    case (sync2)
      2'b01:   req = WALK_L;
      2'b10:   req = WALK_R;
      default: req = IDLE;
    endcase
  end

  assign phase_adv  = (state == IDLE) ? 2'd0 : next_phase(phase);
  assign anim_state = state;

  // A tick landing on the boundary cycle counts as pending for that commit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      phase        <= '0;
      tick_pending <= 1'b0;
      frame_sel    <= FRAME_IDLE;
      frame_update <= 1'b0;
    end else begin
      tick_pending <= tick_pending | tick;
      frame_update <= 1'b0;
      if (frame_start) begin
        if (req != state) begin
          state        <= req;
          phase        <= '0;
          tick_pending <= 1'b0;
          frame_sel    <= frame_of(req, 2'd0);
          frame_update <= 1'b1;
        end else if (tick_pending || tick) begin
          phase        <= phase_adv;
          tick_pending <= 1'b0;
          frame_sel    <= frame_of(state, phase_adv);
          frame_update <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sprite_anim_ctrl.sv
// Directed bench for sprite_anim_ctrl with TICK_DIV=8 and 20-cycle frame spacing.
module tb_sprite_anim_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] btn = '0;
  logic       frame_start = 1'b0;
  logic [2:0] frame_sel;
  logic [1:0] anim_state;
  logic       frame_update;

  int checks = 0;
  int errors = 0;

  sprite_anim_ctrl #(.TICK_DIV(8), .CNT_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .btn          (btn),
    .frame_start  (frame_start),
    .frame_sel    (frame_sel),
    .anim_state   (anim_state),
    .frame_update (frame_update)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp)
      else begin
        errors++;
        $error("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
  endtask

  // Run gap-1 quiet cycles then one frame_start cycle; check outputs after the commit edge.
  task automatic frame(input int gap, input string tag, input int b,
                       input int exp_fu, input int exp_sel, input int exp_as);
    logic [2:0] sel0;
    logic [1:0] as0;
    int         stable;
    btn    = b[4:0];
    sel0   = frame_sel;
    as0    = anim_state;
    stable = 1;
    frame_start = 1'b0;
    for (int i = 0; i < gap - 1; i++) begin
      step();
      if (frame_sel !== sel0 || anim_state !== as0 || frame_update !== 1'b0) stable = 0;
    end
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    chk({tag, " stable"}, stable, 1);
    chk({tag, " frame_update"}, int'(frame_update), exp_fu);
    chk({tag, " frame_sel"}, int'(frame_sel), exp_sel);
    chk({tag, " anim_state"}, int'(anim_state), exp_as);
  endtask

  localparam int BL  = 5'b10101;  // left plus ignored bits
  localparam int L   = 5'b00100;
  localparam int R   = 5'b01000;
  localparam int RX  = 5'b01010;  // right plus an ignored bit
  localparam int LR  = 5'b01100;
  localparam int NB  = 5'b00000;

`ifdef SPRITE_PINGPONG_EN
  localparam int L5 = 2, L6 = 1, L7 = 2;
  localparam int R15 = 5, R16 = 4, R17 = 5;
`else
  localparam int L5 = 1, L6 = 2, L7 = 3;
  localparam int R15 = 4, R16 = 5, R17 = 6;
`endif

  initial begin
    // Reset held
    #2;
    chk("reset frame_sel", int'(frame_sel), 0);
    chk("reset anim_state", int'(anim_state), 0);
    chk("reset frame_update", int'(frame_update), 0);
    #20 rst = 1'b1;

    // Idle commits still pulse frame_update
    frame(20, "idle0", NB, 1, 0, 0);
    frame(20, "idle1", NB, 1, 0, 0);
    // Hold left
    frame(20, "left0", BL, 1, 1, 1);
    frame(20, "left1", L,  1, 2, 1);
    frame(20, "left2", L,  1, 3, 1);
    frame(20, "left3", L,  1, L5, 1);
    frame(20, "left4", L,  1, L6, 1);
    frame(20, "left5", L,  1, L7, 1);
    frame(20, "both",  LR, 1, 0, 0);
    // Left to frame 3, then switch right
    frame(20, "relft0", L, 1, 1, 1);
    frame(20, "relft1", L, 1, 2, 1);
    frame(20, "relft2", L, 1, 3, 1);
    frame(20, "right0", RX, 1, 4, 2);
    frame(20, "right1", R,  1, 5, 2);
    frame(20, "right2", R,  1, 6, 2);
    frame(20, "right3", R,  1, R15, 2);
    frame(20, "right4", R,  1, R16, 2);
    frame(20, "right5", R,  1, R17, 2);
    frame(20, "release", NB, 1, 0, 0);
    // Last commit at edge 380; next tick is sampled at edge 384
    frame(4, "coinc_idle", NB, 1, 0, 0);
    frame(2, "no_stale", NB, 0, 0, 0);
    frame(6, "coinc_dir", L, 1, 1, 1);
    frame(7, "no_tick", L, 0, 1, 1);
    frame(1, "tick_only", L, 1, 2, 1);

    // Async reset mid-walk, away from any clock edge
    step();
    step();
    #2 rst = 1'b0;
    #1;
    chk("async frame_sel", int'(frame_sel), 0);
    chk("async anim_state", int'(anim_state), 0);
    chk("async frame_update", int'(frame_update), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sprite_anim_ctrl.md
# sprite_anim_ctrl

Animation sequencer for the player sprite in the draw path. It watches the push-buttons, runs a walk-cycle state machine and paces frames with an internal tick divider. Every change to the selected sprite frame is committed only at a video frame boundary, so a sprite is never torn mid-scan. The draw controller uses `frame_sel` to pick which sprite ROM output feeds the block pixel.

## Interface
Parameters:
- `TICK_DIV`, default 25555556: clock cycles per animation tick; legal range 2..2^27-1.
- `CNT_W`, default 27: width of the tick counter.

Ports:
- `clk` in 1: pixel/system clock.
- `rst` in 1: asynchronous, active-low reset.
- `btn` in 5: raw push-buttons. Bit 2 is left and bit 3 is right; all other bits are ignored.
- `frame_start` in 1: one-cycle pulse at the start of a video frame (curr_x==0 && curr_y==0).
- `frame_sel` out 3: sprite ROM select. 0 = idle, 1–3 = left walk 1–3, 4–6 = right walk 1–3. The value 7 is never driven.
- `anim_state` out 2: 0 = IDLE, 1 = WALK_L, 2 = WALK_R.
- `frame_update` out 1: one-cycle pulse in the same cycle that `frame_sel` or `anim_state` takes a newly committed value.

## Operation
- **Button sync.** `btn[2]` and `btn[3]` pass through a 2-flop synchronizer. The requested direction is:
  - WALK_L if left only;
  - WALK_R if right only;
  - IDLE if neither or both are pressed.
- **Tick divider.**
  - The counter runs 0..TICK_DIV-1 and wraps.
  - `tick` is asserted for one cycle when the count equals TICK_DIV-1.
  - `tick` sets `tick_pending`.
- **Commit rule.** Nothing changes except in a cycle with `frame_start`=1:
  - **Direction change** (requested != current state): move to the requested state and set `phase`=0. This happens whether or not `tick_pending` is set, and `tick_pending` is cleared.
  - **Same state, `tick_pending`=1 or `tick`=1:**
    - in a walk state, `phase` advances one step (wraps per the sequence length);
    - in IDLE, `phase` stays 0;
    - `tick_pending` is cleared.
  - **Same state, no pending tick:** no change and no `frame_update`.
- **Frame mapping.**
  - IDLE → 0.
  - WALK_L → seq[phase].
  - WALK_R → seq[phase]+3.
  - seq is defined under Configuration.
- **`frame_update`** pulses on every commit that reaches the action branches above, including an IDLE tick where the value does not change.
- **Simultaneous `tick` and `frame_start`:** the tick counts as pending in that same cycle.
- **`tick` while already pending:** no accumulation; one pending flag only.

## Timing
- **Reset values** (all asynchronous):
  - `frame_sel`=0, `anim_state`=IDLE, `frame_update`=0;
  - `phase`=0, `tick_pending`=0, tick counter=0, synchronizer flops=0.
- **Reset mid-walk:** every output returns to its reset value immediately. No commit is needed.
- **Outputs are registered.** A commit at the `frame_start` edge produces new `frame_sel`, new `anim_state` and a `frame_update` pulse one cycle later.
- **Button-to-commit latency:** 2 cycles of sync, then the next `frame_start`.
- **First tick:** pulses TICK_DIV cycles after reset release; after that, exactly every TICK_DIV cycles.

## Configuration
- **`SPRITE_PINGPONG_EN` defined:**
  - walk sequence seq = 1,2,3,2 (4 phases, phase 0..3);
  - this matches the back-and-forth leg swing.
- **`SPRITE_PINGPONG_EN` undefined:**
  - seq = 1,2,3 (3 phases, phase 0..2), wrapping 3→1.
  - The phase counter stays 2 bits; the value 3 is unreachable, and if ever seen it maps to phase 0.

## Structure
- **Package `sprite_anim_pkg`:**
  - state encodings IDLE/WALK_L/WALK_R;
  - frame index constants FRAME_IDLE=0, FRAME_L_BASE=0, FRAME_R_BASE=3;
  - button bit indices BTN_LEFT=2, BTN_RIGHT=3;
  - default TICK_DIV.
- **Sub-module `anim_tick_div`:** the parameterised divider (`clk`, `rst`, `tick`). It is the one natural split.
- **Top level:** the synchronizer, FSM, phase counter and output registers.

## Test plan
All scenarios use TICK_DIV=8 and `frame_start` every 20 cycles.
1. **Reset, then idle.** Hold reset, release, no buttons → `frame_sel`=0 and `anim_state`=0 throughout. `frame_update` pulses once per `frame_start` that follows a tick.
2. **Hold left, `SPRITE_PINGPONG_EN` defined.** First commit → `anim_state`=1, `frame_sel`=1. Later commits give `frame_sel` 2,3,2,1,2… on successive commits.
3. **Hold right, macro undefined.** `frame_sel` runs 4,5,6,4,5,6…; the value 7 never appears.
4. **Left to right mid-cycle.** While walking left at `frame_sel`=3, switch to right → the next `frame_start` gives `frame_sel`=4 without waiting for a tick. Press both buttons → next commit gives `frame_sel`=0, `anim_state`=0.
5. **Edge timing and async reset.**
   - Tick coincident with `frame_start` → the commit happens in that cycle and no stale pending flag is left.
   - Buttons changing between `frame_start` pulses → outputs stay stable until the boundary.
   - Assert `rst` low mid-walk → `frame_sel`=0 and `anim_state`=0 asynchronously, without waiting for a `clk` edge.
